tt_pulse_monitor: RTL
=====================

// Module: tt_pulse_monitor
// PURPOSE
//  Clocked consumer placed directly downstream of a toggle-output (TT) RSFQ buffer stage.
//  Each input pulse of that stage flips its output q, so every level change on tt_in is one pulse.
//  This block does four things:
//   - synchronises q and decodes each level change into one pulse event;
//   - timestamps each event and counts all pulses;
//   - checks spacing between pulses against a critical-timing window, in cycles;
//   - queues events in a small FIFO behind a valid/ready interface.
// PARAMETERS
//  SYNC_STAGES  2   flops in tt_in synchroniser (>=2)
//  TS_WIDTH     16  free-running timestamp width
//  CNT_WIDTH    16  pulse counter width
//  FIFO_DEPTH   4   event queue entries (power of 2, >=2)
//  CT_CYCLES    2   min cycles between accepted transitions; closer = violation
// PORTS
//  clk          in   1          single clock, rising edge
//  rst_n        in   1          synchronous active-low reset
//  tt_in        in   1          toggle-encoded pulse stream (upstream buffer q)
//  clr          in   1          sync clear of pulse_count, ct_violation, overflow
//  ev_valid     out  1          FIFO head valid
//  ev_ready     in   1          consumer accepts head
//  ev_ts        out  TS_WIDTH   head event timestamp
//  ev_viol      out  1          head event violated CT_CYCLES spacing
//  pulse_count  out  CNT_WIDTH  pulses seen since reset/clr, wraps
//  ct_violation out  1          sticky: any spacing violation
//  overflow     out  1          sticky: event dropped, FIFO full
// BEHAVIOUR
//  Reset (rst_n=0 at edge):
//   - sync chain, prev and ts are cleared to 0.
//   - FIFO is flushed; ev_valid is 0.
//   - pulse_count, ct_violation and overflow are 0.
//   - gap counter is set to CT_CYCLES (saturated).
//   - ev_ts and ev_viol read 0 when the FIFO is empty.
//  Timestamp:
//   - ts increments every non-reset cycle and wraps mod 2^TS_WIDTH.
//   - ts is 0 after the reset-release edge E0 and equals k after edge Ek.
//  Detect:
//   - det = s[SYNC_STAGES-1] ^ prev.
//   - prev <= s[last] every edge.
//   - A tt_in change set up before edge En gives det=1 in the cycle after En+SYNC_STAGES-1.
//   - The event is taken at edge En+SYNC_STAGES with ev_ts = ts of the det cycle.
//   - Because the chain resets to 0, tt_in=1 held across reset yields one event after release.
//  Spacing:
//   - gap counts cycles since the last det and saturates at CT_CYCLES.
//   - On det: ev_viol = (gap < CT_CYCLES); gap <= 1.
//   - The first det after reset or clr is never a violation.
//   - A violation sets ct_violation.
//  Counting: every det increments pulse_count (wraps), including dropped events.
//  FIFO (registered, first-word-fall-through):
//   - ev_valid = !empty; a pop happens at an edge where ev_valid & ev_ready.
//   - An event written into an empty FIFO at edge Ew shows ev_valid=1 after Ew, i.e. 1-edge write latency.
//   - det while full with no pop in the same cycle: event dropped, overflow <= 1.
//   - det while full with a pop in the same cycle: both occur, no overflow.
//   - Order is strict FIFO; head fields hold steady while ev_valid & !ev_ready.
//  clr:
//   - Has priority over same-cycle increment and flag set: count=0, flags=0.
//   - gap <= CT_CYCLES.
//   - FIFO is not flushed; a same-cycle event is still enqueued, with ev_viol computed before the clear.
//  Reset mid-operation discards queued events; no partial state survives.
// TESTING
//  T1 latency: E0 release, tt_in 0->1 before E5, ev_ready=1
//      -> ev_valid=1 after E7, ev_ts=6, ev_viol=0, pulse_count=1.
//  T2 spacing: toggles before E5 and E6 (CT_CYCLES=2)
//      -> 2nd event ev_viol=1, ct_violation=1, pulse_count=2.
//  T3 overflow: ev_ready=0, 5 toggles 3 cycles apart
//      -> 4 queued, overflow=1, pulse_count=5;
//      -> then ev_ready=1 drains 4 with ev_ts stepping by 3, then ev_valid=0.
//  T4 full+pop: FIFO full, ev_ready=1 in the same cycle as det
//      -> occupancy stays 4, overflow=0, new event last.
//  T5 clr: 2 events queued, count=2, ct_violation=1; clr one cycle
//      -> count=0, flags=0, both events still drain intact.
//  T6 reset: 2 queued, tt_in=1; rst_n low one edge
//      -> ev_valid=0, count=0;
//      -> exactly one event after release with ts=SYNC_STAGES.

Source files
------------

// File: rtl/tt_pulse_monitor_if.sv
// Event stream between tt_pulse_monitor and its consumer: FIFO head plus ready handshake.
// The monitor drives the head fields through master; the consumer returns ev_ready through slave.
interface tt_pulse_monitor_if #(
    parameter int TS_WIDTH = 16
) ();
    logic                ev_valid;
    logic                ev_ready;
    logic [TS_WIDTH-1:0] ev_ts;
    logic                ev_viol;

    modport master (
        output ev_valid,
        output ev_ts,
        output ev_viol,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_ts,
        input  ev_viol,
        output ev_ready
    );
endinterface

// File: rtl/tt_pulse_monitor.sv
// Decodes the toggle-encoded output of a TT RSFQ buffer into timestamped pulse events,
// counts pulses, checks pulse spacing against CT_CYCLES and queues events in a FWFT FIFO.
module tt_pulse_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int TS_WIDTH    = 16,
    parameter int CNT_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int CT_CYCLES   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tt_in,
    input  logic                 clr,
    tt_pulse_monitor_if.master   ev,
    output logic [CNT_WIDTH-1:0] pulse_count,
    output logic                 ct_violation,
    output logic                 overflow
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int GAP_W = $clog2(CT_CYCLES + 1);

    localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(CT_CYCLES);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);
    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Synchroniser, edge detector and timestamp state
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic [TS_WIDTH-1:0]    ts_r;

    // Spacing checker and statistics
    logic [GAP_W-1:0]       gap_r;
    logic [CNT_WIDTH-1:0]   count_r;
    logic                   ct_viol_r;
    logic                   overflow_r;

    // Event queue storage; pointers carry one extra wrap bit to tell full from empty
    logic [TS_WIDTH-1:0]    mem_ts_r [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  mem_viol_r;
    logic [AW:0]            wptr_r;
    logic [AW:0]            rptr_r;

    logic                   det_s;
    logic                   viol_s;
    logic                   empty_s;
    logic                   full_s;
    logic                   pop_s;
    logic                   push_s;
    logic                   drop_s;
    logic [TS_WIDTH-1:0]    head_ts_s;
    logic                   head_viol_s;

    function automatic logic [AW:0] ptr_next(input logic [AW:0] ptr);
        return ptr + PTR_ONE;
    endfunction

    // Pulse decode, spacing verdict and FIFO qualifiers for the current cycle
    always_comb begin
        det_s   = sync_r[SYNC_STAGES-1] ^ prev_r;
        viol_s  = det_s & (gap_r < GAP_SAT);
        empty_s = (wptr_r == rptr_r);
        full_s  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
        pop_s   = ~empty_s & ev.ev_ready;
        // A pop in the same cycle frees the slot a full queue needs for the new event
        push_s  = det_s & (~full_s | pop_s);
        drop_s  = det_s & full_s & ~pop_s;
    end

    // Head of queue; fields read as zero while the queue is empty
    always_comb begin
        head_ts_s   = {TS_WIDTH{1'b0}};
        head_viol_s = 1'b0;
        if (empty_s) begin
            head_ts_s   = {TS_WIDTH{1'b0}};
            head_viol_s = 1'b0;
        end else begin
            head_ts_s   = mem_ts_r[rptr_r[AW-1:0]];
            head_viol_s = mem_viol_r[rptr_r[AW-1:0]];
        end
    end

    assign ev.ev_valid   = ~empty_s;
    assign ev.ev_ts      = head_ts_s;
    assign ev.ev_viol    = head_viol_s;
    assign pulse_count   = count_r;
    assign ct_violation  = ct_viol_r;
    assign overflow      = overflow_r;

    // Input synchroniser, previous-level register and free-running timestamp
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            prev_r <= 1'b0;
            ts_r   <= {TS_WIDTH{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], tt_in};
            prev_r <= sync_r[SYNC_STAGES-1];
            ts_r   <= ts_r + TS_WIDTH'(1);
        end
    end

    // Cycles since the last pulse, saturating so the first pulse after reset/clr is clean
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_r <= GAP_SAT;
        end else if (clr) begin
            gap_r <= GAP_SAT;
        end else if (det_s) begin
            gap_r <= GAP_ONE;
        end else if (gap_r < GAP_SAT) begin
            gap_r <= gap_r + GAP_ONE;
        end else begin
            gap_r <= gap_r;
        end
    end

    // Pulse counter and sticky flags; clr wins over any same-cycle update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r    <= {CNT_WIDTH{1'b0}};
            ct_viol_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else if (clr) begin
            count_r    <= {CNT_WIDTH{1'b0}};
            ct_viol_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            count_r    <= det_s ? (count_r + CNT_WIDTH'(1)) : count_r;
            ct_viol_r  <= ct_viol_r | viol_s;
            overflow_r <= overflow_r | drop_s;
        end
    end

    // Event queue write/read; clr leaves queued events untouched
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_r     <= {(AW + 1){1'b0}};
            rptr_r     <= {(AW + 1){1'b0}};
            mem_viol_r <= {FIFO_DEPTH{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_ts_r[i] <= {TS_WIDTH{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_ts_r[wptr_r[AW-1:0]]   <= ts_r;
                mem_viol_r[wptr_r[AW-1:0]] <= viol_s;
                wptr_r                     <= ptr_next(wptr_r);
            end else begin
                wptr_r <= wptr_r;
            end
            if (pop_s) begin
                rptr_r <= ptr_next(rptr_r);
            end else begin
                rptr_r <= rptr_r;
            end
        end
    end

endmodule
